// File: rtl/seg7_scan_if.sv
// Load-side inputs and display-side outputs of the seg7_scan multiplexed LED driver.
interface seg7_scan_if #(
    parameter int DIGITS   = 4,
    parameter int BRIGHT_W = 3
);
    logic                load;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [BRIGHT_W-1:0] bright;
    logic                pending;
    logic                frame_tick;
    logic [DIGITS-1:0]   io_sel;
    logic [7:0]          io_seg;

    modport master (
        output load, value, dp, blank, bright,
        input  pending, frame_tick, io_sel, io_seg
    );

    modport slave (
        input  load, value, dp, blank, bright,
        output pending, frame_tick, io_sel, io_seg
    );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner with frame-synchronous double-buffered updates
// and per-slot PWM brightness.
module seg7_scan #(
    parameter int DIGITS      = 4,
    parameter int DIV_W       = 16,
    parameter int BRIGHT_W    = 3,
    parameter bit SEL_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    seg7_scan_if.slave bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_ACT_LOW}};
    localparam logic [7:0]        SEG_OFF  = {8{SEG_ACT_LOW}};

    typedef struct packed {
        logic [4*DIGITS-1:0] value;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blank;
        logic [BRIGHT_W-1:0] bright;
    } frameCfg_t;

    logic [DIV_W-1:0]  slotCnt_q, slotCnt_d;
    logic [IDX_W-1:0]  digitIdx_q, digitIdx_d;
    logic              frameTick_q, frameTick_d;
    logic              pending_q, pending_d;
    frameCfg_t         shadow_q, shadow_d;
    frameCfg_t         active_q, active_d;
    logic              actValid_q, actValid_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [7:0]        seg_q, seg_d;

    logic              frameBoundary;
    frameCfg_t         loadCfg;
    logic [3:0]        curNibble;
    logic [6:0]        segPattern;
    logic [BRIGHT_W-1:0] pwmLevel;
    logic              digitOn;

    assign frameBoundary = (digitIdx_q == LAST_IDX) && (slotCnt_q == '1);
    assign loadCfg       = '{value: bus.value, dp: bus.dp, blank: bus.blank, bright: bus.bright};

    always_comb begin
        slotCnt_d   = slotCnt_q + 1'b1;
        digitIdx_d  = digitIdx_q;
        frameTick_d = frameBoundary;
        if (slotCnt_q == '1) begin
            digitIdx_d = (digitIdx_q == LAST_IDX) ? '0 : digitIdx_q + 1'b1;
        end
    end

    // A load landing on the boundary itself bypasses the shadow so it is never left pending.
    // actValid keeps the display dark until something has actually been committed.
    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        actValid_d = actValid_q;
        pending_d  = pending_q;
        if (bus.load) begin
            shadow_d = loadCfg;
        end
        if (frameBoundary) begin
            if (bus.load) begin
                active_d   = loadCfg;
                actValid_d = 1'b1;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                active_d   = shadow_q;
                actValid_d = 1'b1;
                pending_d  = 1'b0;
            end
        end else if (bus.load) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        curNibble = active_q.value[{digitIdx_q, 2'b00} +: 4];
        case (curNibble)
            4'h0:    segPattern = 7'h3F;
            4'h1:    segPattern = 7'h06;
            4'h2:    segPattern = 7'h5B;
            4'h3:    segPattern = 7'h4F;
            4'h4:    segPattern = 7'h66;
            4'h5:    segPattern = 7'h6D;
            4'h6:    segPattern = 7'h7D;
            4'h7:    segPattern = 7'h07;
            4'h8:    segPattern = 7'h7F;
            4'h9:    segPattern = 7'h67;
            4'hA:    segPattern = 7'h77;
            4'hB:    segPattern = 7'h7C;
            4'hC:    segPattern = 7'h39;
            4'hD:    segPattern = 7'h5E;
            4'hE:    segPattern = 7'h79;
            default: segPattern = 7'h71;
        endcase
    end

    // PWM compares the top bits of the slot counter, so all-ones brightness is always on.
    always_comb begin
        pwmLevel = slotCnt_q[DIV_W-1 -: BRIGHT_W];
        digitOn  = actValid_q && !active_q.blank[digitIdx_q] && (pwmLevel <= active_q.bright);
        sel_d    = SEL_OFF;
        seg_d    = SEG_OFF;
        if (digitOn) begin
            sel_d = (DIGITS'(1) << digitIdx_q) ^ SEL_OFF;
            seg_d = {active_q.dp[digitIdx_q], segPattern} ^ SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slotCnt_q   <= '0;
            digitIdx_q  <= '0;
            frameTick_q <= 1'b0;
            pending_q   <= 1'b0;
            shadow_q    <= '0;
            active_q    <= '0;
            actValid_q  <= 1'b0;
            sel_q       <= SEL_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            slotCnt_q   <= slotCnt_d;
            digitIdx_q  <= digitIdx_d;
            frameTick_q <= frameTick_d;
            pending_q   <= pending_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            actValid_q  <= actValid_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_tick = frameTick_q;
    assign bus.io_sel     = sel_q;
    assign bus.io_seg     = seg_q;
endmodule
